// File: rtl/matrix_host_seq.sv
// matrix_host_seq: bus master on the M0 port of the matrix-multiply subsystem.
// For each job it streams A and B operands into the S1/S2 RAMs and writes the
// controller start register. It then waits for m_interrupt, reads the S3
// result RAM back as an output stream, and clears the interrupt.
module matrix_host_seq #(
   parameter int unsigned N_A        = 16,
   parameter int unsigned N_B        = 16,
   parameter int unsigned N_R        = 16,
   parameter logic [7:0]  A_BASE     = 8'h10,
   parameter logic [7:0]  B_BASE     = 8'h20,
   parameter logic [7:0]  R_BASE     = 8'h40,
   parameter logic [7:0]  START_ADDR = 8'h00,
   parameter logic [7:0]  CLR_ADDR   = 8'h01,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        M0_req,
   output logic        M0_wr,
   output logic [7:0]  M0_address,
   output logic [31:0] M0_dout,
   input  logic        M0_grant,
   input  logic [31:0] M_din,
   input  logic        m_interrupt
);

   localparam int unsigned TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [4:0]  LAST_A = 5'(N_A - 1);
   localparam logic [4:0]  LAST_B = 5'(N_B - 1);
   localparam logic [4:0]  LAST_R = 5'(N_R - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_START,
      S_WAIT_INT,
      S_READ_R,
      S_CLEAR
   } state_t;

   state_t        state;
   logic [4:0]    idx;
   logic [TW-1:0] timer;
   logic          rd_pend;
   logic          xfer;

   assign busy = (state != S_IDLE);
   assign xfer = M0_req && M0_grant;

   // Bus request, address, write data and operand handshake decoded from the state.
   // These are combinational so that M0_req tracks in_valid and drops with reset.
   always_comb begin
      M0_req     = 1'b0;
      M0_wr      = 1'b0;
      M0_address = '0;
      M0_dout    = '0;
      in_ready   = 1'b0;
      case (state)
         S_LOAD_A: begin
            M0_req     = in_valid;
            M0_wr      = 1'b1;
            M0_address = A_BASE + {3'b000, idx};
            M0_dout    = in_data;
            in_ready   = in_valid && M0_grant;
         end
         S_LOAD_B: begin
            M0_req     = in_valid;
            M0_wr      = 1'b1;
            M0_address = B_BASE + {3'b000, idx};
            M0_dout    = in_data;
            in_ready   = in_valid && M0_grant;
         end
         S_START: begin
            M0_req     = 1'b1;
            M0_wr      = 1'b1;
            M0_address = START_ADDR;
            M0_dout    = 32'h1;
         end
         S_READ_R: begin
            M0_req     = 1'b1;
            M0_address = R_BASE + {3'b000, idx};
         end
         S_CLEAR: begin
            M0_req     = 1'b1;
            M0_wr      = 1'b1;
            M0_address = CLR_ADDR;
            M0_dout    = 32'h1;
         end
         default: ;
      endcase
   end

   // Job sequencing, wait timer, read-return pipeline and registered status pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         timer     <= '0;
         rd_pend   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done    <= 1'b0;
         rd_pend <= 1'b0;
         // M_din is valid in the cycle after a granted read; capture it at its end.
         out_valid <= rd_pend;
         if (rd_pend) begin
            out_data <= M_din;
         end
         case (state)
            S_IDLE: begin
               if (go) begin
                  err   <= 1'b0;
                  idx   <= '0;
                  state <= S_LOAD_A;
               end
            end
            S_LOAD_A: begin
               if (xfer) begin
                  if (idx == LAST_A) begin
                     idx   <= '0;
                     state <= S_LOAD_B;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            S_LOAD_B: begin
               if (xfer) begin
                  if (idx == LAST_B) begin
                     idx   <= '0;
                     state <= S_START;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            S_START: begin
               if (M0_grant) begin
                  timer <= '0;
                  state <= S_WAIT_INT;
               end
            end
            S_WAIT_INT: begin
               // The interrupt takes priority over a timeout reached in the same cycle.
               if (m_interrupt) begin
                  idx   <= '0;
                  state <= S_READ_R;
               end else if (timer == T_LAST) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_READ_R: begin
               if (xfer) begin
                  rd_pend <= 1'b1;
                  if (idx == LAST_R) begin
                     idx   <= '0;
                     state <= S_CLEAR;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            S_CLEAR: begin
               if (M0_grant) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_host_seq.sv
// Testbench for matrix_host_seq. It provides an operand source, a bus arbiter
// and a result-RAM/interrupt responder, and checks the DUT against transaction-level
// expectations.
`timescale 1ns/1ps
module tb_matrix_host_seq;

   localparam int unsigned TMO = 8;
   localparam int unsigned NW  = 16;

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic        go          = 1'b0;
   logic        in_valid    = 1'b0;
   logic [31:0] in_data     = '0;
   logic        M0_grant    = 1'b0;
   logic [31:0] M_din       = '0;
   logic        m_interrupt = 1'b0;

   logic        in_ready, out_valid, busy, done, err, M0_req, M0_wr;
   logic [31:0] out_data, M0_dout;
   logic [7:0]  M0_address;

   matrix_host_seq #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(rst), .go(go),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .done(done), .err(err),
      .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
      .M0_grant(M0_grant), .M_din(M_din), .m_interrupt(m_interrupt)
   );

   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Result RAM contents as seen on the bus.
   function automatic logic [31:0] ram(input logic [7:0] a);
      return {16'hC0DE, a, ~a};
   endfunction

   // Bench environment state.
   logic [31:0] feed_q[$];
   logic [40:0] log_q[$];
   bit          gnt_mode = 0;
   bit          gap_mode = 0;
   bit          int_en   = 1;
   bit          cmp_en   = 0;
   logic        phase    = 1'b0;
   int unsigned g_cnt    = 0;
   int unsigned int_cnt  = 0;
   int unsigned cyc      = 0;
   int unsigned start_cyc = 0;
   logic        exp_v0 = 1'b0, exp_v1 = 1'b0;
   logic [31:0] exp_d0 = '0, exp_d1 = '0;
   logic        hold_v = 1'b0;
   logic [40:0] hold_val = '0;

   int unsigned done_cnt = 0, ov_cnt = 0, done_cyc = 0, last_ov_cyc = 0, err_cyc = 0;
   logic [31:0] first_out = '0;
   logic        err_q = 1'b0;

   wire xfer = M0_req && M0_grant;
   wire pop  = in_valid && in_ready;

   always @(posedge clk) cyc <= cyc + 1;

   // Environment: arbiter, operand source, result RAM, interrupt source, bus log,
   // expected output timing (result word appears two cycles after the granted read cycle).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         in_valid    <= 1'b0;
         in_data     <= '0;
         m_interrupt <= 1'b0;
         int_cnt     <= 0;
         M_din       <= '0;
         exp_v0      <= 1'b0;
         exp_v1      <= 1'b0;
         hold_v      <= 1'b0;
      end else begin
         if (hold_v && M0_req) check("bus_hold", {M0_wr, M0_address, M0_dout}, hold_val);
         hold_v   <= M0_req && !M0_grant;
         hold_val <= {M0_wr, M0_address, M0_dout};

         if (xfer) log_q.push_back({M0_wr, M0_address, M0_dout});
         if (xfer && M0_wr && M0_address == 8'h00 && M0_dout == 32'h1) begin
            start_cyc <= cyc + 1;
            if (int_en) int_cnt <= 3;
         end else if (int_cnt != 0) begin
            int_cnt <= int_cnt - 1;
            if (int_cnt == 1) m_interrupt <= 1'b1;
         end
         if (xfer && M0_wr && M0_address == 8'h01 && M0_dout == 32'h1) m_interrupt <= 1'b0;

         M_din  <= (xfer && !M0_wr) ? ram(M0_address) : 32'hFFFF_FFFF;
         exp_v0 <= xfer && !M0_wr;
         exp_d0 <= ram(M0_address);
         exp_v1 <= exp_v0;
         exp_d1 <= exp_d0;

         phase    <= ~phase;
         in_valid <= (feed_q.size() > (pop ? 1 : 0)) && (!gap_mode || !phase);
         if (pop) in_data <= (feed_q.size() > 1) ? feed_q[1] : 32'h0;
         else     in_data <= (feed_q.size() > 0) ? feed_q[0] : 32'h0;
         if (pop) void'(feed_q.pop_front());

         g_cnt    <= (g_cnt == 2) ? 0 : g_cnt + 1;
         M0_grant <= !gnt_mode || (g_cnt == 2);
      end
   end

   // Per-cycle compare against the environment's expectations.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("out_valid", out_valid, exp_v1);
         if (exp_v1) check("out_data", out_data, exp_d1);
         check("in_ready", in_ready,
               M0_req && M0_grant && M0_wr && M0_address >= 8'h10 && M0_address <= 8'h2F);
         if (M0_req && M0_wr && M0_address >= 8'h10 && M0_address <= 8'h2F)
            check("load_dout", M0_dout, in_data);
         if (M0_req && !M0_wr) check("read_dout", M0_dout, 32'h0);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", busy, 1'b0);
         end
         if (out_valid) begin
            if (ov_cnt == 0) first_out = out_data;
            ov_cnt++;
            last_ov_cyc = cyc;
         end
         if (err && !err_q) err_cyc = cyc;
         err_q = err;
      end
   end

   function automatic int n_reads();
      int n = 0;
      foreach (log_q[i]) if (!log_q[i][40]) n++;
      return n;
   endfunction

   task automatic load_operands(input logic [31:0] a0, input logic [31:0] b0);
      for (int i = 0; i < NW; i++) feed_q.push_back(a0 + 32'(i));
      for (int i = 0; i < NW; i++) feed_q.push_back(b0 + 32'(i));
   endtask

   task automatic run_job(input string tag, input logic [31:0] a0, input logic [31:0] b0,
                          input bit tmo, input bit go_mid);
      logic [40:0] exp_q[$];
      logic [7:0]  ad;
      bit          fin;
      int          mid;
      mid = 0;
      log_q.delete();
      done_cnt = 0;
      ov_cnt   = 0;
      for (int i = 0; i < NW; i++) begin
         ad = 8'h10 + 8'(i);
         exp_q.push_back({1'b1, ad, a0 + 32'(i)});
      end
      for (int i = 0; i < NW; i++) begin
         ad = 8'h20 + 8'(i);
         exp_q.push_back({1'b1, ad, b0 + 32'(i)});
      end
      exp_q.push_back({1'b1, 8'h00, 32'h1});
      if (!tmo) begin
         for (int i = 0; i < NW; i++) begin
            ad = 8'h40 + 8'(i);
            exp_q.push_back({1'b0, ad, 32'h0});
         end
         exp_q.push_back({1'b1, 8'h01, 32'h1});
      end
      load_operands(a0, b0);
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check({tag, "_busy_after_go"}, busy, 1'b1);
      check({tag, "_err_cleared"}, err, 1'b0);
      fin = 0;
      for (int c = 0; c < 3000 && !fin; c++) begin
         @(negedge clk);
         if (go_mid) begin
            if (mid == 1) begin
               go  = 1'b0;
               mid = 2;
            end else if (mid == 0 && log_q.size() >= 20) begin
               go  = 1'b1;
               mid = 1;
            end
         end
         fin = tmo ? (err && !busy) : (done_cnt != 0);
      end
      go = 1'b0;
      check({tag, "_finished"}, fin, 1'b1);
      repeat (4) @(negedge clk);
      check({tag, "_bus_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_bus%0d", tag, i), log_q[i], exp_q[i]);
      check({tag, "_done_count"}, done_cnt, tmo ? 0 : 1);
      check({tag, "_out_count"}, ov_cnt, tmo ? 0 : NW);
      check({tag, "_err"}, err, tmo);
      check({tag, "_busy_end"}, busy, 1'b0);
      if (tmo) check({tag, "_err_delay"}, err_cyc - start_cyc, TMO);
      else     check({tag, "_done_after_out"}, done_cyc >= last_ov_cyc, 1'b1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_req", M0_req, 1'b0);
      check("rst_wr", M0_wr, 1'b0);
      check("rst_addr", M0_address, 8'h00);
      check("rst_dout", M0_dout, 32'h0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      rst    = 1'b0;
      cmp_en = 1;
      repeat (2) @(negedge clk);

      // Full job, grant tied high, A=1..16, B=17..32; literal pins on the log.
      run_job("job1", 32'd1, 32'd17, 0, 0);
      check("pin_a0", log_q[0], {1'b1, 8'h10, 32'd1});
      check("pin_a15", log_q[15], {1'b1, 8'h1F, 32'd16});
      check("pin_b0", log_q[16], {1'b1, 8'h20, 32'd17});
      check("pin_start", log_q[32], {1'b1, 8'h00, 32'h1});
      check("pin_rd0", log_q[33], {1'b0, 8'h40, 32'h0});
      check("pin_clr", log_q[49], {1'b1, 8'h01, 32'h1});
      check("pin_first_out", first_out, 32'hC0DE40BF);

      // Grant high one cycle in three.
      gnt_mode = 1;
      run_job("gnt", 32'h100, 32'h200, 0, 0);
      gnt_mode = 0;

      // Operand source valid every other cycle.
      gap_mode = 1;
      run_job("gap", 32'h300, 32'h400, 0, 0);
      gap_mode = 0;

      // No interrupt: timeout after TMO cycles in the wait.
      int_en = 0;
      run_job("tmo", 32'h500, 32'h600, 1, 0);
      int_en = 1;

      // go pulsed during LOAD_B is ignored; this go also clears err.
      run_job("gomid", 32'h700, 32'h800, 0, 1);

      // Reset in READ_R after five reads.
      log_q.delete();
      load_operands(32'h900, 32'hA00);
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      begin
         bit reached;
         reached = 0;
         for (int c = 0; c < 3000 && !reached; c++) begin
            @(negedge clk);
            reached = (n_reads() >= 5);
         end
         check("rst_mid_reached", reached, 1'b1);
      end
      #2 rst = 1'b1;
      #1;
      check("rst_mid_req", M0_req, 1'b0);
      check("rst_mid_out_valid", out_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      feed_q.delete();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_job("after_rst", 32'hB00, 32'hC00, 0, 0);
      check("pin_restart_a0", log_q[0], {1'b1, 8'h10, 32'hB00});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
